// File: rtl/sub_serial_32_bit.sv
// Purpose: multi-cycle X - Y, one CHUNK-bit slice per clock with the borrow carried in a register.
// Latency: done pulses the cycle after edge k+NCHUNK when start is accepted at edge k.
// Backpressure: start is ignored while busy; a request during the done cycle is accepted.
module sub_serial_32_bit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int BW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [CW-1:0]    cnt;
  logic             cin;
  logic [WIDTH-1:0] shadow;

  logic [BW-1:0]    base;
  logic [CHUNK-1:0] x_c;
  logic [CHUNK-1:0] y_c;
  logic [CHUNK:0]   sum;
  logic [WIDTH-1:0] merged;
  logic             last;
  logic             accept;

  // Slice the current chunk and add it with the inverted subtrahend; merged is the
  // full-width result the shadow would hold once this chunk is written back.
  always_comb begin
    base   = BW'(cnt) * BW'(CHUNK);
    x_c    = x_q[base +: CHUNK];
    y_c    = y_q[base +: CHUNK];
    sum    = {1'b0, x_c} + {1'b0, ~y_c} + {{CHUNK{1'b0}}, cin};
    merged = shadow;
    merged[base +: CHUNK] = sum[CHUNK-1:0];
    last   = (cnt == LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; the done cycle accepts a new start like idle.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, chunk ripple, and result/flag update on the final chunk only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      cnt      <= '0;
      cin      <= 1'b0;
      shadow   <= '0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (accept) begin
      x_q    <= X;
      y_q    <= Y;
      cnt    <= '0;
      cin    <= 1'b1;
      shadow <= '0;
    end else if (state == S_RUN) begin
      shadow <= merged;
      cin    <= sum[CHUNK];
      if (last) begin
        cnt      <= '0;
        diff     <= merged;
        borrow   <= ~sum[CHUNK];
        overflow <= (x_q[WIDTH-1] != y_q[WIDTH-1]) && (merged[WIDTH-1] != x_q[WIDTH-1]);
        zero     <= (merged == '0);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sub_serial_32_bit.sv
// Scoreboarded bench for sub_serial_32_bit: directed corner operands, ignored starts,
// mid-run reset, back-to-back starts and randomized traffic against an arithmetic model.
// Stimulus drives just after the falling edge; the monitor samples on the falling edge.
module tb_sub_serial_32_bit;

  localparam int NCHUNK = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] X;
  logic [31:0] Y;
  logic        busy;
  logic        done;
  logic [31:0] diff;
  logic        borrow;
  logic        overflow;
  logic        zero;

  sub_serial_32_bit #(.WIDTH(32), .CHUNK(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .X        (X),
    .Y        (Y),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    logic        b;
    logic        o;
    logic        z;
    int          at;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   accepts = 0;

  logic [31:0] held_d = '0;
  logic [2:0]  held_f = '0;
  int          busy_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic on the whole operands.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input int at);
    exp_t   e;
    longint sd;
    sd   = longint'($signed(x)) - longint'($signed(y));
    e.d  = x - y;
    e.b  = (x < y);
    e.o  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    e.z  = (x == y);
    e.at = at;
    return e;
  endfunction

  // One stimulus cycle; a start seen while the block is not busy is a new operation.
  task automatic drive(input logic s, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    #1;
    start = s;
    X     = x;
    Y     = y;
    if (s && rst_n && !busy) begin
      q.push_back(model(x, y, cyc + NCHUNK + 1));
      accepts++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, $urandom, $urandom);
  endtask

  task automatic op(input logic [31:0] x, input logic [31:0] y);
    drive(1'b1, x, y);
    idle(NCHUNK + 1);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    start = 1'b0;
    q.delete();
    repeat (n) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: reset values, result on done, and result hold on every other cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_diff", diff, 32'd0);
      chk("rst_flags", 32'({borrow, overflow, zero}), 32'd0);
      held_d   = '0;
      held_f   = '0;
      busy_cnt = 0;
    end else if (done) begin
      chk("done_busy", 32'(busy), 32'd0);
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation (t=%0t)", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("diff", diff, e.d);
        chk("flags_bovz", 32'({borrow, overflow, zero}), 32'({e.b, e.o, e.z}));
        chk("latency_cycle", 32'(cyc), 32'(e.at));
        chk("busy_cycles", 32'(busy_cnt), 32'(NCHUNK));
        held_d = e.d;
        held_f = {e.b, e.o, e.z};
      end
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      chk("hold_diff", diff, held_d);
      chk("hold_flags", 32'({borrow, overflow, zero}), 32'(held_f));
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    X     = '0;
    Y     = '0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Directed corners.
    op(32'd5, 32'd3);
    op(32'd0, 32'd1);
    op(32'h0000_00FF, 32'h0000_0100);
    op(32'h8000_0000, 32'd1);
    op(32'h7FFF_FFFF, 32'hFFFF_FFFF);
    op(32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Start pulse during busy must be ignored.
    drive(1'b1, 32'd10, 32'd4);
    drive(1'b0, 32'd0, 32'd0);
    drive(1'b1, 32'd100, 32'd1);
    idle(NCHUNK + 2);

    // Reset during the second RUN cycle aborts with no done.
    drive(1'b1, 32'd10, 32'd4);
    drive(1'b0, 32'd0, 32'd0);
    do_reset(1);
    idle(NCHUNK + 2);
    op(32'd10, 32'd4);

    // Start held high: one accept per NCHUNK+1 cycles.
    accepts = 0;
    repeat (5 * (NCHUNK + 1)) drive(1'b1, $urandom, $urandom);
    chk("b2b_accepts", 32'(accepts), 32'd5);
    idle(NCHUNK + 2);

    // Randomized traffic with stray starts while busy.
    repeat (40) begin
      drive(1'b1, $urandom, $urandom);
      repeat ($urandom_range(0, 7)) drive(($urandom_range(0, 3) == 0), $urandom, $urandom);
    end

    // Drain with a bounded wait.
    for (int i = 0; i < 60 && q.size() > 0; i++) idle(1);
    idle(2);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending results expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
